uart_cmd_assembler: RTL and testbench

Receive-side counterpart of the remote command transmitter. Sits between the on-board UART receiver and the command processor. It consumes the two-byte command stream (high byte first, then low byte), reassembles the 16-bit command, and presents it with a level `cmd_rdy` flag. It also enforces an optional inter-byte gap timeout and reports overrun and framing errors.

---
 rtl/knight_cmd_pkg.sv | 13 +
 rtl/gap_timer.sv | 44 ++++
 rtl/uart_cmd_assembler.sv | 127 ++++++++++++
 tb/tb_uart_cmd_assembler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_cmd_pkg.sv
// Shared definitions for the remote command link: payload widths and the
// receive-side assembler state encoding.
package knight_cmd_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } asm_state_t;

endpackage : knight_cmd_pkg

// File: rtl/gap_timer.sv
// Inter-byte gap timer for the command assembler. Only built when the
// CMD_TIMEOUT_EN macro is defined; the default build has no timer at all.
// Loaded with TIMEOUT_CYCLES-1 on clr, counts down while en, and reports
// expired once the count hits zero (it then holds there, no wrap).
`ifdef CMD_TIMEOUT_EN
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on clear, otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register; reset leaves the full window remaining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule : gap_timer
`endif

// File: rtl/uart_cmd_assembler.sv
// Reassembles two-byte commands (high byte first) from the UART receiver
// into a 16-bit command with a level ready flag, plus sticky overrun and
// framing error flags. Optional inter-byte timeout under CMD_TIMEOUT_EN.
module uart_cmd_assembler
  import knight_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic              clr_err,
  output logic              cmd_ovr,
  output logic              frame_err
);

  asm_state_t        state_q,     state_d;
  logic [BYTE_W-1:0] high_q,      high_d;
  logic [CMD_W-1:0]  cmd_q,       cmd_d;
  logic              cmd_rdy_q,   cmd_rdy_d;
  logic              cmd_ovr_q,   cmd_ovr_d;
  logic              frame_err_q, frame_err_d;

  logic complete_c;
  logic ovr_event_c;
  logic timeout_c;

`ifdef CMD_TIMEOUT_EN
  logic expired_c;

  // Timer runs only while a high byte is held; idle keeps it reloaded.
  gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == IDLE),
    .en      (state_q == WAIT_LOW),
    .expired (expired_c)
  );

  // A byte arriving on the terminal-count cycle takes precedence.
  assign timeout_c = (state_q == WAIT_LOW) && expired_c && !rx_rdy;
`else
  logic unused_timeout_c;

  assign timeout_c        = 1'b0;
  assign unused_timeout_c = (TIMEOUT_CYCLES == 0);
`endif

  // The UART cannot be stalled, so every presented byte is acknowledged.
  assign clr_rx_rdy = rst_n & rx_rdy;

  // Next-state logic: byte capture, command completion, timeout and flags.
  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    complete_c  = 1'b0;
    ovr_event_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          high_d  = rx_data;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (rx_rdy) begin
          cmd_d      = {high_q, rx_data};
          cmd_rdy_d  = 1'b1;
          complete_c = 1'b1;
          state_d    = IDLE;
        end else if (timeout_c) begin
          high_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completion in the same cycle as the acknowledge keeps the flag set.
    if (!complete_c && clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    ovr_event_c = complete_c && cmd_rdy_q && !clr_cmd_rdy;

    // Error events win over a simultaneous clear.
    cmd_ovr_d   = ovr_event_c | (cmd_ovr_q & ~clr_err);
    frame_err_d = timeout_c   | (frame_err_q & ~clr_err);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      high_q      <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      cmd_ovr_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      cmd_ovr_q   <= cmd_ovr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign cmd_ovr   = cmd_ovr_q;
  assign frame_err = frame_err_q;

endmodule : uart_cmd_assembler

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: directed scenarios followed by
// randomized byte traffic, compared against a transaction-level model.
// Timeout scenarios are exercised when CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_assembler;

  localparam int unsigned T = 16;
`ifdef CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        clr_err;
  logic        cmd_ovr;
  logic        frame_err;

  uart_cmd_assembler #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .clr_err     (clr_err),
    .cmd_ovr     (cmd_ovr),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model state, expressed in terms of received bytes and edges.
  bit          m_pending;
  logic [7:0]  m_high;
  logic [15:0] m_cmd;
  bit          m_rdy;
  bit          m_ovr;
  bit          m_ferr;
  int          edge_n;
  int          high_edge;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, predict the rising edge, check after it.
  task automatic cycle(input bit rst, input bit rdy, input logic [7:0] d,
                       input bit ccr, input bit cer);
    bit complete;
    bit ovr_ev;
    bit ferr_ev;
    rst_n       = rst;
    rx_rdy      = rdy;
    rx_data     = d;
    clr_cmd_rdy = ccr;
    clr_err     = cer;
    #1;
    check_eq("clr_rx_rdy", 16'(clr_rx_rdy), 16'(rst & rdy));
    if (clr_rx_rdy === 1'b1) pulses++;

    edge_n++;
    complete = 1'b0;
    ovr_ev   = 1'b0;
    ferr_ev  = 1'b0;
    if (!rst) begin
      m_pending = 1'b0;
      m_high    = '0;
      m_cmd     = '0;
      m_rdy     = 1'b0;
      m_ovr     = 1'b0;
      m_ferr    = 1'b0;
    end else begin
      if (rdy && !m_pending) begin
        m_pending = 1'b1;
        m_high    = d;
        high_edge = edge_n;
      end else if (rdy) begin
        complete  = 1'b1;
        ovr_ev    = m_rdy && !ccr;
        m_cmd     = {m_high, d};
        m_rdy     = 1'b1;
        m_pending = 1'b0;
      end else if (m_pending && TO_EN && (edge_n - high_edge == int'(T))) begin
        m_pending = 1'b0;
        ferr_ev   = 1'b1;
      end
      if (ccr && !complete) m_rdy = 1'b0;
      m_ovr  = ovr_ev  || (m_ovr  && !cer);
      m_ferr = ferr_ev || (m_ferr && !cer);
    end

    @(negedge clk);
    check_eq("cmd",       cmd,                m_cmd);
    check_eq("cmd_rdy",   16'(cmd_rdy),       16'(m_rdy));
    check_eq("cmd_ovr",   16'(cmd_ovr),       16'(m_ovr));
    check_eq("frame_err", 16'(frame_err),     16'(m_ferr));
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_all();
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = '0;
    clr_cmd_rdy = 1'b0;
    clr_err     = 1'b0;
    edge_n      = 0;
    high_edge   = 0;
    m_pending   = 1'b0;
    m_high      = '0;
    m_cmd       = '0;
    m_rdy       = 1'b0;
    m_ovr       = 1'b0;
    m_ferr      = 1'b0;
    @(negedge clk);

    // Reset with a byte waiting: no acknowledge while in reset.
    cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("rst_cmd", cmd, 16'h0000);
    check_eq("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);

    // Normal command, back-to-back bytes.
    pulses = 0;
    send(8'hA5);
    check_eq("half_cmd_rdy", 16'(cmd_rdy), 16'h0);
    send(8'h3C);
    check_eq("normal_cmd", cmd, 16'hA53C);
    check_eq("normal_rdy", 16'(cmd_rdy), 16'h1);
    check_eq("normal_pulses", 16'(pulses), 16'd2);

    // Acknowledge, then a second command.
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("ack_rdy", 16'(cmd_rdy), 16'h0);
    check_eq("ack_cmd_hold", cmd, 16'hA53C);
    send(8'h12);
    send(8'h34);
    check_eq("second_cmd", cmd, 16'h1234);

    // Overrun, then coincident acknowledge avoids overrun.
    clear_all();
    send(8'h01); send(8'h02);
    send(8'h03); send(8'h04);
    check_eq("ovr_cmd", cmd, 16'h0304);
    check_eq("ovr_flag", 16'(cmd_ovr), 16'h1);
    clear_all();
    check_eq("ovr_cleared", 16'(cmd_ovr), 16'h0);
    send(8'h01); send(8'h02);
    send(8'h03);
    cycle(1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
    check_eq("coinc_ovr", 16'(cmd_ovr), 16'h0);
    check_eq("coinc_rdy", 16'(cmd_rdy), 16'h1);

    // Overrun coincident with clr_err: the event wins.
    send(8'h05);
    cycle(1'b1, 1'b1, 8'h06, 1'b0, 1'b1);
    check_eq("ovr_vs_clr", 16'(cmd_ovr), 16'h1);
    clear_all();

`ifdef CMD_TIMEOUT_EN
    // Timeout after a lone high byte, then a clean command.
    send(8'hFF);
    idle(T - 1);
    check_eq("pre_timeout", 16'(frame_err), 16'h0);
    idle(1);
    check_eq("timeout_ferr", 16'(frame_err), 16'h1);
    send(8'h0A); send(8'h0B);
    check_eq("post_timeout_cmd", cmd, 16'h0A0B);
    clear_all();
    // Low byte on the terminal-count cycle completes the command.
    send(8'hC1);
    idle(T - 1);
    send(8'hC2);
    check_eq("tc_cmd", cmd, 16'hC1C2);
    check_eq("tc_ferr", 16'(frame_err), 16'h0);
    clear_all();
`else
    // Without the timer a long gap never breaks the command.
    send(8'hFF);
    idle(3 * T);
    send(8'h0B);
    check_eq("long_gap_cmd", cmd, 16'hFF0B);
    check_eq("long_gap_ferr", 16'(frame_err), 16'h0);
    clear_all();
`endif

    // Reset mid-command discards the held high byte.
    send(8'h77);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("midrst_cmd", cmd, 16'h0000);
    check_eq("midrst_rdy", 16'(cmd_rdy), 16'h0);
    send(8'h88); send(8'h99);
    check_eq("midrst_next", cmd, 16'h8899);

    // Randomized traffic with occasional long gaps and rare resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        idle(int'($urandom_range(T - 2, T + 2)));
      end else begin
        cycle($urandom_range(0, 99) != 0,
              $urandom_range(0, 2) != 0,
              8'($urandom),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_cmd_assembler
